// File: rtl/delay_calibrator.sv
// Acoustic speaker->mic delay calibrator: emits a probe pulse, then scans mic samples for the echo.
// Optional macro CALIB_PEAK_SEARCH_EN selects peak-search mode instead of first-crossing mode.
module delay_calibrator #(
  parameter logic [15:0]        MAX_DELAY = 16'd12000,
  parameter logic [15:0]        PULSE_LEN = 16'd8,
  parameter logic signed [15:0] PULSE_AMP = 16'sh4000,
  parameter logic [15:0]        THRESHOLD = 16'd2000
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  input  logic               audio_valid_in,
  input  logic signed [15:0] mic_in,
  output logic signed [15:0] probe_out,
  output logic               busy_out,
  output logic               done_out,
  output logic               delay_valid_out,
  output logic               timeout_out,
  output logic [15:0]        delay_cycle_out
);

  typedef enum logic [1:0] {IDLE, PROBE, LISTEN, DONE} state_t;

  state_t             state_q, state_d;
  logic [15:0]        counter_q, counter_d;
  logic [15:0]        index_q, index_d;
  logic               found_q, found_d;
  logic signed [15:0] probe_q, probe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               delay_valid_q, delay_valid_d;
  logic               timeout_q, timeout_d;
  logic [15:0]        delay_cycle_q, delay_cycle_d;
`ifdef CALIB_PEAK_SEARCH_EN
  logic [15:0]        peak_q, peak_d;
`endif

  logic [15:0] mag;
  logic        hit;

  // Saturating magnitude: -32768 has no positive twin, so it clamps to 32767.
  always_comb begin
    mag = 16'd0;
    if (mic_in == 16'sh8000)
      mag = 16'h7fff;
    else if (mic_in < 16'sd0)
      mag = $unsigned(-mic_in);
    else
      mag = $unsigned(mic_in);
    hit = (mag > THRESHOLD);
  end

  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    index_d       = index_q;
    found_d       = found_q;
    probe_d       = probe_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    delay_valid_d = delay_valid_q;
    timeout_d     = timeout_q;
    delay_cycle_d = delay_cycle_q;
`ifdef CALIB_PEAK_SEARCH_EN
    peak_d        = peak_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d       = PROBE;
          counter_d     = 16'd0;
          index_d       = 16'd0;
          found_d       = 1'b0;
          probe_d       = PULSE_AMP;
          busy_d        = 1'b1;
          delay_valid_d = 1'b0;
          timeout_d     = 1'b0;
`ifdef CALIB_PEAK_SEARCH_EN
          peak_d        = 16'd0;
`endif
        end
      end

      // mic_in is deliberately ignored here to blank electrical crosstalk.
      PROBE: begin
        if (audio_valid_in) begin
          if (counter_q == PULSE_LEN - 16'd1) begin
            probe_d   = 16'sd0;
            counter_d = PULSE_LEN;
            state_d   = LISTEN;
          end else begin
            counter_d = counter_q + 16'd1;
          end
        end
      end

      LISTEN: begin
        if (audio_valid_in) begin
`ifdef CALIB_PEAK_SEARCH_EN
          // Strict compare keeps the earliest index on ties.
          if (hit && (mag > peak_q)) begin
            peak_d  = mag;
            index_d = counter_q;
            found_d = 1'b1;
          end
          if (counter_q == MAX_DELAY - 16'd1)
            state_d = DONE;
          else
            counter_d = counter_q + 16'd1;
`else
          if (hit) begin
            index_d = counter_q;
            found_d = 1'b1;
            state_d = DONE;
          end else if (counter_q == MAX_DELAY - 16'd1) begin
            state_d = DONE;
          end else begin
            counter_d = counter_q + 16'd1;
          end
`endif
        end
      end

      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (found_q) begin
          delay_valid_d = 1'b1;
          delay_cycle_d = index_q;
        end else begin
          timeout_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      counter_q     <= 16'd0;
      index_q       <= 16'd0;
      found_q       <= 1'b0;
      probe_q       <= 16'sd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      delay_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      delay_cycle_q <= 16'd0;
`ifdef CALIB_PEAK_SEARCH_EN
      peak_q        <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      index_q       <= index_d;
      found_q       <= found_d;
      probe_q       <= probe_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      delay_valid_q <= delay_valid_d;
      timeout_q     <= timeout_d;
      delay_cycle_q <= delay_cycle_d;
`ifdef CALIB_PEAK_SEARCH_EN
      peak_q        <= peak_d;
`endif
    end
  end

  assign probe_out       = probe_q;
  assign busy_out        = busy_q;
  assign done_out        = done_q;
  assign delay_valid_out = delay_valid_q;
  assign timeout_out     = timeout_q;
  assign delay_cycle_out = delay_cycle_q;

endmodule

// File: tb/tb_delay_calibrator.sv
// Scoreboard bench for delay_calibrator: directed echo scenarios, results checked on each done_out pulse.
module tb_delay_calibrator;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               audio_valid;
  logic signed [15:0] mic;
  logic signed [15:0] probe_out;
  logic               busy_out;
  logic               done_out;
  logic               delay_valid_out;
  logic               timeout_out;
  logic [15:0]        delay_cycle_out;

  typedef struct {
    logic        valid;
    logic        timeout;
    logic [15:0] delay;
  } exp_t;

  exp_t expQ[$];
  int   checkCount = 0;
  int   passCount  = 0;
  int   doneCount  = 0;
  int   samplesSent;

  always #5 clk = ~clk;

  delay_calibrator dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .start_in        (start),
    .audio_valid_in  (audio_valid),
    .mic_in          (mic),
    .probe_out       (probe_out),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .delay_valid_out (delay_valid_out),
    .timeout_out     (timeout_out),
    .delay_cycle_out (delay_cycle_out)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected)
      passCount++;
    else
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done_out === 1'b1) begin
      doneCount++;
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_done: actual=1 required=0");
      end else begin
        e = expQ.pop_front();
        checkOutput("delay_valid", delay_valid_out, e.valid);
        checkOutput("timeout", timeout_out, e.timeout);
        checkOutput("delay_cycle", delay_cycle_out, e.delay);
      end
    end
  end

  function automatic logic [15:0] micFor(input int test, input int idx);
    case (test)
      1: return (idx == 300)  ? 16'd5000 : 16'd0;
      2: return (idx == 1200) ? 16'h8000 : 16'd0;
      3: return (idx < 8)     ? 16'd9000 : 16'd0;
      4: return (idx == 500)  ? 16'd3000 : (idx == 900) ? 16'd8000 : 16'd0;
      5: return (idx == 300)  ? 16'd5000 : 16'd0;
      default: return 16'd0;
    endcase
  endfunction

  task automatic sendSample(input logic [15:0] value, input int gap);
    @(negedge clk);
    audio_valid = 1'b1;
    mic = value;
    @(negedge clk);
    audio_valid = 1'b0;
    mic = 16'sd0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic applyStimulus(input int test, input exp_t e, input int restartAt, input int stopAt);
    int startDone;
    startDone = doneCount;
    if (stopAt < 0) expQ.push_back(e);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_on_start", busy_out, 1'b1);
    samplesSent = 0;
    for (int i = 0; i < 12000 && doneCount == startDone; i++) begin
      if (i == stopAt) return;
      if (i == 0 || i == 7) checkOutput("probe_high", probe_out, 16'h4000);
      if (i == 8) checkOutput("probe_low", probe_out, 16'h0000);
      if (i == restartAt) start = 1'b1;
      sendSample(micFor(test, i), (test == 1 && i < 400) ? 4 : 1);
      start = 1'b0;
      samplesSent = i + 1;
    end
    for (int k = 0; k < 20 && doneCount == startDone; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    checkOutput("done_pulses", doneCount - startDone, 1);
    checkOutput("busy_after_done", busy_out, 1'b0);
    if (doneCount == startDone && expQ.size() > 0) void'(expQ.pop_front());
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_probe"}, probe_out, 16'h0000);
    checkOutput({tag, "_busy"}, busy_out, 1'b0);
    checkOutput({tag, "_done"}, done_out, 1'b0);
    checkOutput({tag, "_valid"}, delay_valid_out, 1'b0);
    checkOutput({tag, "_timeout"}, timeout_out, 1'b0);
    checkOutput({tag, "_delay"}, delay_cycle_out, 16'h0000);
  endtask

  initial begin
    exp_t e;
    int   abortDone;
    rst = 1'b1;
    start = 1'b0;
    audio_valid = 1'b0;
    mic = 16'sd0;
    repeat (5) @(negedge clk);
    checkIdleOutputs("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkIdleOutputs("idle");

    $display("[TB] echo at sample 300");
    e = '{1'b1, 1'b0, 16'd300};
    applyStimulus(1, e, -1, -1);

    $display("[TB] saturating negative echo at sample 1200");
    e = '{1'b1, 1'b0, 16'd1200};
    applyStimulus(2, e, -1, -1);

    $display("[TB] crosstalk blanking, expect timeout");
    e = '{1'b0, 1'b1, 16'd1200};
    applyStimulus(3, e, -1, -1);
    checkOutput("timeout_window", samplesSent, 12000);

    $display("[TB] first-crossing vs peak mode");
`ifdef CALIB_PEAK_SEARCH_EN
    e = '{1'b1, 1'b0, 16'd900};
`else
    e = '{1'b1, 1'b0, 16'd500};
`endif
    applyStimulus(4, e, -1, -1);

    $display("[TB] reset abort at sample 100");
    abortDone = doneCount;
    applyStimulus(0, e, -1, 100);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkIdleOutputs("abort");
    repeat (20) @(negedge clk);
    checkOutput("abort_no_done", doneCount - abortDone, 0);

    $display("[TB] restart mid-listen ignored");
    e = '{1'b1, 1'b0, 16'd300};
    applyStimulus(5, e, 50, -1);

    checkOutput("queue_drained", expQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
